// File: rtl/ckp_gen_if.sv
// Control and pattern-output bundle of the crank-position generator.
// The master side sets run/period/polarity; the slave side (ckp_gen) drives the pattern.
interface ckp_gen_if #(
    parameter int PER_WIDTH = 24
);
    logic                 ena;
    logic [PER_WIDTH-1:0] period;
    logic                 pol;
    logic                 cap;
    logic [5:0]           tooth_num;
    logic                 gap;
    logic                 rev_pulse;
    logic                 busy;

    modport master (
        output ena, period, pol,
        input  cap, tooth_num, gap, rev_pulse, busy
    );

    modport slave (
        input  ena, period, pol,
        output cap, tooth_num, gap, rev_pulse, busy
    );
endinterface

// File: rtl/ckp_gen.sv
// Crank-position pattern generator: synthesizes a missing-tooth wheel signal
// with registered tooth index, gap flag and a once-per-revolution strobe.
module ckp_gen #(
    parameter int PER_WIDTH = 24,
    parameter int TOOTH_TOP = 57,
    parameter int GAP_SLOTS = 2
) (
    input  logic     clk,
    input  logic     rst,
    ckp_gen_if.slave bus
);
    localparam int                   CW         = PER_WIDTH + 2;
    localparam logic [CW-1:0]        ONE        = CW'(1);
    localparam logic [PER_WIDTH-1:0] P_MIN      = PER_WIDTH'(4);
    localparam logic [5:0]           LAST_TOOTH = 6'(TOOTH_TOP);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PER_WIDTH-1:0] p_q, p_d, p_in;
    logic [5:0]           tooth_q, tooth_d;
    logic                 rev_d;
    logic                 cap_q, gap_q, rev_q, busy_q;

    function automatic logic [CW-1:0] high_cycles(input logic [PER_WIDTH-1:0] p);
        return CW'(p >> 1) - ONE;
    endfunction

    assign p_in = (bus.period < P_MIN) ? P_MIN : bus.period;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        tooth_d = tooth_q;
        rev_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ena) begin
                    state_d = HIGH;
                    p_d     = p_in;
                    cnt_d   = high_cycles(p_in);
                    tooth_d = '0;
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    cnt_d   = CW'(p_q - (p_q >> 1)) - ONE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else if (!bus.ena) begin
                    state_d = IDLE;
                    tooth_d = '0;
                end else if (tooth_q < LAST_TOOTH) begin
                    state_d = HIGH;
                    p_d     = p_in;
                    cnt_d   = high_cycles(p_in);
                    tooth_d = tooth_q + 6'd1;
                end else begin
                    // tooth_num holds the last tooth index through the gap
                    state_d = GAP;
                    cnt_d   = CW'(GAP_SLOTS) * CW'(p_q) - ONE;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else if (!bus.ena) begin
                    state_d = IDLE;
                    tooth_d = '0;
                end else begin
                    state_d = HIGH;
                    p_d     = p_in;
                    cnt_d   = high_cycles(p_in);
                    tooth_d = '0;
                    rev_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            tooth_q <= '0;
            cap_q   <= 1'b0;
            gap_q   <= 1'b0;
            rev_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            tooth_q <= tooth_d;
            cap_q   <= (state_d == HIGH) ^ bus.pol;
            gap_q   <= (state_d == GAP);
            rev_q   <= rev_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.cap       = cap_q;
    assign bus.tooth_num = tooth_q;
    assign bus.gap       = gap_q;
    assign bus.rev_pulse = rev_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_ckp_gen.sv
// Self-checking bench for ckp_gen: table-driven wheel measurements, corner
// sequences, and a randomized run against a slot-level reference model.
module tb_ckp_gen;
    localparam int PW  = 24;
    localparam int TOP = 57;
    localparam int GAP_SLOT = TOP + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ckp_gen_if #(.PER_WIDTH(PW)) bus ();

    ckp_gen #(.PER_WIDTH(PW), .TOOTH_TOP(TOP), .GAP_SLOTS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic raw();
        return bus.cap ^ bus.pol;
    endfunction

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) tick();
    endtask

    // ---------------- slot-level reference model ----------------
    typedef struct packed {
        logic       raw;
        logic [5:0] tooth;
        logic       gap;
        logic       rev;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    bit   m_running;
    int   m_slot;
    int   m_last_p;

    task automatic model_push_tooth(input int per, input bit rev);
        int p;
        exp_t e;
        p = (per < 4) ? 4 : per;
        m_last_p = p;
        for (int i = 0; i < p; i++) begin
            e.raw   = (i < p / 2);
            e.tooth = 6'(m_slot);
            e.gap   = 1'b0;
            e.rev   = rev && (i == 0);
            e.busy  = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic model_edge(input bit ena, input int per, output exp_t e);
        exp_t g;
        if (exp_q.size() == 0) begin
            if (!ena) begin
                m_running = 1'b0;
                g = '0;
                exp_q.push_back(g);
            end else if (!m_running) begin
                m_running = 1'b1;
                m_slot = 0;
                model_push_tooth(per, 1'b0);
            end else if (m_slot == TOP) begin
                m_slot = GAP_SLOT;
                for (int i = 0; i < 2 * m_last_p; i++) begin
                    g.raw = 1'b0; g.tooth = 6'(TOP); g.gap = 1'b1; g.rev = 1'b0; g.busy = 1'b1;
                    exp_q.push_back(g);
                end
            end else if (m_slot == GAP_SLOT) begin
                m_slot = 0;
                model_push_tooth(per, 1'b1);
            end else begin
                m_slot++;
                model_push_tooth(per, 1'b0);
            end
        end
        e = exp_q.pop_front();
    endtask

    // ---------------- table-driven wheel measurements ----------------
    typedef struct {
        int period;
        bit pol;
        int hi;
        int lo;
        int gap_len;
        int rev_len;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        int guard, hi, lo, gl, bad, rl;
        string tag;
        tag = $sformatf("vec%0d", idx);
        reset_dut();
        bus.period = PW'(v.period);
        bus.pol    = v.pol;
        bus.ena    = 1'b1;
        rst        = 1'b1;
        guard = 0;
        while (!(bus.tooth_num == 6'd3 && bus.busy) && guard < 2000) begin tick(); guard++; end
        check({tag, " reach tooth3"}, 32'(guard < 2000), 32'd1);
        hi = 0;
        while (bus.tooth_num == 6'd3 && raw() == 1'b1 && hi < 100) begin tick(); hi++; end
        lo = 0;
        while (bus.tooth_num == 6'd3 && raw() == 1'b0 && lo < 100) begin tick(); lo++; end
        check({tag, " high len"}, 32'(hi), 32'(v.hi));
        check({tag, " low len"}, 32'(lo), 32'(v.lo));
        guard = 0;
        while (!bus.gap && guard < 5000) begin tick(); guard++; end
        check({tag, " reach gap"}, 32'(guard < 5000), 32'd1);
        gl = 0; bad = 0;
        while (bus.gap && gl < 1000) begin
            if (raw() != 1'b0) bad++;
            tick();
            gl++;
        end
        check({tag, " gap len"}, 32'(gl), 32'(v.gap_len));
        check({tag, " gap level"}, 32'(bad), 32'd0);
        check({tag, " rev after gap"}, 32'({bus.rev_pulse, bus.tooth_num, raw()}), 32'({1'b1, 6'd0, 1'b1}));
        rl = 1;
        tick();
        check({tag, " rev width"}, 32'(bus.rev_pulse), 32'd0);
        while (!bus.rev_pulse && rl < 2000) begin tick(); rl++; end
        check({tag, " revolution len"}, 32'(rl), 32'(v.rev_len));
    endtask

    initial begin
        int guard, t, hi, lo;
        exp_t e;
        logic [9:0] act_v, exp_v;

        vecs[0] = '{8, 1'b0, 4, 4, 16, 480};
        vecs[1] = '{1, 1'b0, 2, 2, 8, 240};
        vecs[2] = '{7, 1'b0, 3, 4, 14, 420};
        vecs[3] = '{9, 1'b1, 4, 5, 18, 540};
        vecs[4] = '{4, 1'b1, 2, 2, 8, 240};
        vecs[5] = '{3, 1'b1, 2, 2, 8, 240};

        bus.ena = 1'b1; bus.pol = 1'b0; bus.period = PW'(8);

        // Reset sequence and first-cycle latency
        rst = 1'b0;
        repeat (3) tick();
        check("reset cap", 32'(bus.cap), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset tooth", 32'(bus.tooth_num), 32'd0);
        check("reset gap/rev", 32'({bus.gap, bus.rev_pulse}), 32'd0);
        rst = 1'b1;
        tick();
        check("start busy", 32'(bus.busy), 32'd1);
        check("start cap", 32'(bus.cap), 32'd1);
        check("start no rev", 32'({bus.rev_pulse, bus.tooth_num}), 32'd0);
        bus.pol = 1'b1;
        tick();
        check("pol flip cap", 32'(bus.cap), 32'd0);
        bus.pol = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Period update in mid-tooth only affects the next tooth
        reset_dut();
        bus.period = PW'(10); bus.pol = 1'b0; bus.ena = 1'b1; rst = 1'b1;
        guard = 0;
        while (bus.tooth_num != 6'd5 && guard < 2000) begin tick(); guard++; end
        check("upd reach tooth5", 32'(guard < 2000), 32'd1);
        t = 0;
        while (bus.tooth_num == 6'd5 && t < 200) begin
            t++;
            if (t == 2) bus.period = PW'(20);
            tick();
        end
        check("upd tooth5 len", 32'(t), 32'd10);
        hi = 0;
        while (bus.tooth_num == 6'd6 && raw() == 1'b1 && hi < 100) begin tick(); hi++; end
        lo = 0;
        while (bus.tooth_num == 6'd6 && raw() == 1'b0 && lo < 100) begin tick(); lo++; end
        check("upd tooth6 high", 32'(hi), 32'd10);
        check("upd tooth6 low", 32'(lo), 32'd10);

        // Stop request mid-tooth: tooth completes, then IDLE
        reset_dut();
        bus.period = PW'(8); bus.ena = 1'b1; rst = 1'b1;
        guard = 0;
        while (bus.tooth_num != 6'd30 && guard < 2000) begin tick(); guard++; end
        check("stop reach tooth30", 32'(guard < 2000), 32'd1);
        t = 0;
        while (bus.busy && bus.tooth_num == 6'd30 && t < 200) begin
            t++;
            if (t == 2) bus.ena = 1'b0;
            tick();
        end
        check("stop tooth30 len", 32'(t), 32'd8);
        check("stop idle", 32'({bus.busy, bus.tooth_num, bus.gap, bus.cap}), 32'd0);
        repeat (3) tick();
        check("stop stays idle", 32'(bus.busy), 32'd0);
        bus.ena = 1'b1;
        tick();
        check("restart", 32'({bus.busy, bus.tooth_num, bus.rev_pulse, bus.cap}), 32'({1'b1, 6'd0, 1'b0, 1'b1}));

        // Asynchronous reset during the gap
        reset_dut();
        bus.period = PW'(4); bus.pol = 1'b1; bus.ena = 1'b1; rst = 1'b1;
        guard = 0;
        while (!bus.gap && guard < 2000) begin tick(); guard++; end
        check("abort reach gap", 32'(guard < 2000), 32'd1);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("abort async clear", 32'({bus.cap, bus.tooth_num, bus.gap, bus.rev_pulse, bus.busy}), 32'd0);

        // Randomized run against the slot-level model
        reset_dut();
        exp_q.delete();
        m_running = 1'b0; m_slot = 0; m_last_p = 4;
        bus.period = PW'(8); bus.pol = 1'b0; bus.ena = 1'b1;
        rst = 1'b1;
        for (int c = 0; c < 9000; c++) begin
            if ($urandom_range(19, 0) == 0) bus.period = PW'($urandom_range(10, 1));
            if ($urandom_range(49, 0) == 0) bus.pol = ~bus.pol;
            if (bus.ena && $urandom_range(1999, 0) == 0) bus.ena = 1'b0;
            else if (!bus.ena && $urandom_range(4, 0) == 0) bus.ena = 1'b1;
            tick();
            model_edge(bus.ena, int'(bus.period), e);
            act_v = {bus.cap, bus.tooth_num, bus.gap, bus.rev_pulse, bus.busy};
            exp_v = {e.raw ^ bus.pol, e.tooth, e.gap, e.rev, e.busy};
            check($sformatf("random cycle %0d", c), 32'(act_v), 32'(exp_v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
